// File: rtl/i2c_master_driver_pkg.sv
// Shared types for the I2C master transaction sequencer: phy command codes,
// sequencer/issuer state encodings, the latched host request and byte helpers.
package i2c_master_pkg;

    localparam int unsigned DEV_W  = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 3;

    localparam logic [BYTE_W-1:0] ZERO8    = 8'h00;
    localparam logic              RW_WRITE = 1'b0;
    localparam logic              RW_READ  = 1'b1;

    typedef enum logic [CMD_W-1:0] {
        CMD_START     = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_READ_NACK = 3'd2,
        CMD_STOP      = 3'd3,
        CMD_RESTART   = 3'd4
    } phy_cmd_e;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        ADDR_W  = 4'd2,
        REG     = 4'd3,
        WDATA   = 4'd4,
        RESTART = 4'd5,
        ADDR_R  = 4'd6,
        RDATA   = 4'd7,
        STOP    = 4'd8,
        DONE    = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        ISS_IDLE = 2'd0,
        ISS_REQ  = 2'd1,
        ISS_WAIT = 2'd2
    } iss_state_e;

    typedef struct packed {
        logic              rw;
        logic [DEV_W-1:0]  addr;
        logic [BYTE_W-1:0] reg_addr;
        logic [BYTE_W-1:0] wr_data;
    } req_t;

    // Address byte on the wire: 7-bit address followed by the R/W bit.
    function automatic logic [BYTE_W-1:0] addr_byte(input logic [DEV_W-1:0] addr,
                                                    input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_master_driver_if.sv
// Command/response link between the transaction sequencer and the byte engine.
interface i2c_master_driver_if;
    import i2c_master_pkg::*;

    logic [CMD_W-1:0]  phy_cmd;
    logic [BYTE_W-1:0] phy_txd;
    logic              phy_valid;
    logic              phy_ready;
    logic              phy_done;
    logic              phy_ack;
    logic [BYTE_W-1:0] phy_rxd;

    modport master (
        output phy_cmd, phy_txd, phy_valid,
        input  phy_ready, phy_done, phy_ack, phy_rxd
    );

    modport slave (
        input  phy_cmd, phy_txd, phy_valid,
        output phy_ready, phy_done, phy_ack, phy_rxd
    );

endinterface

// File: rtl/i2c_master_driver_cmd_issuer.sv
// Issues one byte-engine command: holds valid until ready, waits for done,
// and bounds the whole exchange with a timeout counter.
module i2c_cmd_issuer
    import i2c_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CMD_W-1:0]    cmd,
    input  logic [BYTE_W-1:0]   txd,
    output logic                active_c,
    output logic                fin_c,
    output logic                tmo_c,
    i2c_master_driver_if.master phy
);

    iss_state_e       ist;
    iss_state_e       ist_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tmo_hit;

    assign tmo_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign active_c = (ist != ISS_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) ist <= ISS_IDLE;
        else        ist <= ist_nxt;
    end

    // A done in the transfer cycle finishes the command directly.
    always_comb begin
        ist_nxt = ist;
        fin_c   = 1'b0;
        tmo_c   = 1'b0;
        case (ist)
            ISS_IDLE: begin
                if (start) ist_nxt = ISS_REQ;
            end
            ISS_REQ: begin
                if (phy.phy_ready && phy.phy_done) begin
                    fin_c   = 1'b1;
                    ist_nxt = ISS_IDLE;
                end else if (tmo_hit) begin
                    tmo_c   = 1'b1;
                    ist_nxt = ISS_IDLE;
                end else if (phy.phy_ready) begin
                    ist_nxt = ISS_WAIT;
                end
            end
            ISS_WAIT: begin
                if (phy.phy_done) begin
                    fin_c   = 1'b1;
                    ist_nxt = ISS_IDLE;
                end else if (tmo_hit) begin
                    tmo_c   = 1'b1;
                    ist_nxt = ISS_IDLE;
                end
            end
            default: ist_nxt = ISS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phy.phy_valid <= 1'b0;
            phy.phy_cmd   <= CMD_STOP;
            phy.phy_txd   <= ZERO8;
            cnt           <= '0;
        end else begin
            phy.phy_valid <= (ist_nxt == ISS_REQ);
            if (ist == ISS_IDLE && start) begin
                phy.phy_cmd <= cmd;
                phy.phy_txd <= txd;
                cnt         <= '0;
            end else if (ist != ISS_IDLE && !tmo_hit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_driver.sv
// I2C master transaction sequencer: turns one host register write/read into the
// START/address/register/data/STOP command stream. Optional address-NACK retry
// is enabled with `define I2C_MASTER_DRIVER_RETRY_EN.
module i2c_master_driver
    import i2c_master_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEV_ADDR       = 7'h3C,
    parameter int unsigned      TIMEOUT_CYCLES = 1024,
    parameter int unsigned      CNT_W          = 11,
    parameter int unsigned      RETRIES        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                rw,
    input  logic                dev_addr_sel,
    input  logic [DEV_W-1:0]    dev_addr,
    input  logic [BYTE_W-1:0]   reg_addr,
    input  logic [BYTE_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic [BYTE_W-1:0]   rd_data,
    output logic                nack_err,
    output logic                timeout_err,
    i2c_master_driver_if.master phy
);

    // Marker block that only elaborates for unsupported parameter sets.
    if (RETRIES > 3 || CNT_W > 31 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_cfg_invalid
    end

    state_e              state;
    state_e              state_nxt;
    req_t                req;
    logic                start_c;
    logic                cmd_state_c;
    logic                wr_state_c;
    logic [CMD_W-1:0]    cmd_c;
    logic [BYTE_W-1:0]   txd_c;
    logic                active_c;
    logic                fin_c;
    logic                tmo_c;
    logic                retry_now_c;
    logic                retry_pend;

    i2c_cmd_issuer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_issuer (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .cmd      (cmd_c),
        .txd      (txd_c),
        .active_c (active_c),
        .fin_c    (fin_c),
        .tmo_c    (tmo_c),
        .phy      (phy)
    );

    assign wr_state_c = (state inside {ADDR_W, REG, WDATA, ADDR_R});

`ifdef I2C_MASTER_DRIVER_RETRY_EN
    logic [1:0] retry_cnt;

    assign retry_now_c = (state == ADDR_W) && fin_c && phy.phy_ack
                         && (retry_cnt < 2'(RETRIES));

    // A NACKed first address byte re-runs the sequence after its STOP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retry_cnt  <= 2'd0;
            retry_pend <= 1'b0;
        end else if (state == IDLE && go) begin
            retry_cnt  <= 2'd0;
            retry_pend <= 1'b0;
        end else if (retry_now_c) begin
            retry_cnt  <= retry_cnt + 2'd1;
            retry_pend <= 1'b1;
        end else if (state == STOP && (fin_c || tmo_c)) begin
            retry_pend <= 1'b0;
        end
    end
`else
    assign retry_now_c = 1'b0;
    assign retry_pend  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_c     = 1'b0;
        cmd_state_c = 1'b1;
        cmd_c       = CMD_STOP;
        txd_c       = ZERO8;
        case (state)
            IDLE: begin
                cmd_state_c = 1'b0;
                if (go) state_nxt = START;
            end
            START: begin
                cmd_c = CMD_START;
                if (fin_c) state_nxt = ADDR_W;
            end
            ADDR_W: begin
                cmd_c = CMD_WRITE;
                txd_c = addr_byte(req.addr, RW_WRITE);
                if (fin_c) state_nxt = phy.phy_ack ? STOP : REG;
            end
            REG: begin
                cmd_c = CMD_WRITE;
                txd_c = req.reg_addr;
                if (fin_c) begin
                    if (phy.phy_ack)            state_nxt = STOP;
                    else if (req.rw == RW_READ) state_nxt = RESTART;
                    else                        state_nxt = WDATA;
                end
            end
            WDATA: begin
                cmd_c = CMD_WRITE;
                txd_c = req.wr_data;
                if (fin_c) state_nxt = STOP;
            end
            RESTART: begin
                cmd_c = CMD_RESTART;
                if (fin_c) state_nxt = ADDR_R;
            end
            ADDR_R: begin
                cmd_c = CMD_WRITE;
                txd_c = addr_byte(req.addr, RW_READ);
                if (fin_c) state_nxt = phy.phy_ack ? STOP : RDATA;
            end
            RDATA: begin
                cmd_c = CMD_READ_NACK;
                if (fin_c) state_nxt = STOP;
            end
            STOP: begin
                cmd_c = CMD_STOP;
                if (fin_c)      state_nxt = retry_pend ? START : DONE;
                else if (tmo_c) state_nxt = DONE;
            end
            DONE: begin
                cmd_state_c = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                cmd_state_c = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
        if (tmo_c && state != STOP) state_nxt = STOP;
        start_c = cmd_state_c && !active_c;
    end

    // Host-facing status and the request latched at go.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_data     <= ZERO8;
            nack_err    <= 1'b0;
            timeout_err <= 1'b0;
            req         <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && go) begin
                req         <= '{rw:       rw,
                                 addr:     dev_addr_sel ? dev_addr : DEV_ADDR,
                                 reg_addr: reg_addr,
                                 wr_data:  wr_data};
                nack_err    <= 1'b0;
                timeout_err <= 1'b0;
                busy        <= 1'b1;
            end
            if (tmo_c) timeout_err <= 1'b1;
            if (fin_c && wr_state_c && phy.phy_ack && !retry_now_c) nack_err <= 1'b1;
            if (fin_c && state == RDATA) rd_data <= phy.phy_rxd;
            if (state == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule
